// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: pointers, read-pointer synchroniser and flags in wr_clk.
// Optional occupancy output wr_level is enabled by defining FIFO_WR_LEVEL_EN.
module async_fifo_wr_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rstn,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_din,
    input  logic [ADDR_SIZE:0]    rd_ptr_gray,
    input  logic                  ovf_clr,
    output logic                  ram_wr_en,
    output logic [ADDR_SIZE-1:0]  ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
`ifdef FIFO_WR_LEVEL_EN
    output logic [ADDR_SIZE:0]    wr_ptr_gray,
    output logic [ADDR_SIZE:0]    wr_level
`else
    output logic [ADDR_SIZE:0]    wr_ptr_gray
`endif
);

    localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0] DEPTH_W = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] AF_W    = (ADDR_SIZE+1)'(AF_THRESH);

    function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
        logic [ADDR_SIZE:0] b;
        b[ADDR_SIZE] = g[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDR_SIZE:0] bin2gray(input logic [ADDR_SIZE:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    logic [ADDR_SIZE:0] wr_bin_r;
    logic [ADDR_SIZE:0] wr_gray_r;
    logic [ADDR_SIZE:0] sync_r [SYNC_STAGES];
    logic               full_r;
    logic               af_r;
    logic               ovf_r;

    logic               accept_s;
    logic [ADDR_SIZE:0] wr_bin_next_s;
    logic [ADDR_SIZE:0] wr_gray_next_s;
    logic [ADDR_SIZE:0] rq_sync_s;
    logic [ADDR_SIZE:0] rd_bin_sync_s;
    logic [ADDR_SIZE:0] used_next_s;
    logic [ADDR_SIZE:0] free_next_s;
    logic [ADDR_SIZE:0] full_cmp_s;
    logic               full_next_s;
    logic               af_next_s;
    logic               ovf_next_s;

    // Next-pointer, occupancy and flag computation.
    always_comb begin
        accept_s       = wr_req & ~full_r;
        wr_bin_next_s  = wr_bin_r;
        wr_gray_next_s = wr_gray_r;
        rq_sync_s      = sync_r[SYNC_STAGES-1];
        rd_bin_sync_s  = gray2bin(rq_sync_s);
        used_next_s    = {(ADDR_SIZE+1){1'b0}};
        free_next_s    = DEPTH_W;
        full_cmp_s     = {~rq_sync_s[ADDR_SIZE:ADDR_SIZE-1], rq_sync_s[ADDR_SIZE-2:0]};
        full_next_s    = 1'b0;
        af_next_s      = 1'b0;
        ovf_next_s     = ovf_r;

        if (accept_s) begin
            wr_bin_next_s = wr_bin_r + PTR_ONE;
        end else begin
            wr_bin_next_s = wr_bin_r;
        end
        wr_gray_next_s = bin2gray(wr_bin_next_s);

        // MSB of the pointers separates full (MSBs differ) from empty (MSBs equal).
        full_next_s = (wr_gray_next_s == full_cmp_s);
        used_next_s = wr_bin_next_s - rd_bin_sync_s;
        free_next_s = DEPTH_W - used_next_s;
        af_next_s   = (free_next_s <= AF_W);

        // A new rejected push outranks a simultaneous clear.
        if (wr_req & full_r) begin
            ovf_next_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Read-pointer synchroniser: plain flop chain, no logic between stages.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {(ADDR_SIZE+1){1'b0}};
            end
        end else begin
            sync_r[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Write pointers and status flags.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wr_bin_r  <= {(ADDR_SIZE+1){1'b0}};
            wr_gray_r <= {(ADDR_SIZE+1){1'b0}};
            full_r    <= 1'b0;
            af_r      <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            wr_bin_r  <= wr_bin_next_s;
            wr_gray_r <= wr_gray_next_s;
            full_r    <= full_next_s;
            af_r      <= af_next_s;
            ovf_r     <= ovf_next_s;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    logic [ADDR_SIZE:0] level_r;

    // Registered occupancy, aligned with the flags.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            level_r <= {(ADDR_SIZE+1){1'b0}};
        end else begin
            level_r <= used_next_s;
        end
    end

    assign wr_level = level_r;
`endif

    // No RAM write is issued while the block is held in reset.
    assign ram_wr_en   = accept_s & wr_rstn;
    assign ram_wr_addr = wr_bin_r[ADDR_SIZE-1:0];
    assign ram_wr_data = wr_din;
    assign full        = full_r;
    assign almost_full = af_r;
    assign overflow    = ovf_r;
    assign wr_ptr_gray = wr_gray_r;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl: counts-based reference model, expected-write queue and negedge monitor.
module tb_async_fifo_wr_ctrl;
    localparam int DW    = 16;
    localparam int AS    = 4;
    localparam int SS    = 2;
    localparam int AF    = 2;
    localparam int DEPTH = 16;

    logic          wr_clk = 1'b0;
    logic          wr_rstn;
    logic          wr_req;
    logic [DW-1:0] wr_din;
    logic [AS:0]   rd_ptr_gray;
    logic          ovf_clr;
    logic          ram_wr_en;
    logic [AS-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic [AS:0]   wr_ptr_gray;
`ifdef FIFO_WR_LEVEL_EN
    logic [AS:0]   wr_level;
`endif

    async_fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AS), .SYNC_STAGES(SS), .AF_THRESH(AF)) dut (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .wr_req(wr_req), .wr_din(wr_din),
        .rd_ptr_gray(rd_ptr_gray), .ovf_clr(ovf_clr), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .full(full),
        .almost_full(almost_full), .overflow(overflow),
`ifdef FIFO_WR_LEVEL_EN
        .wr_level(wr_level),
`endif
        .wr_ptr_gray(wr_ptr_gray)
    );

    always #5 wr_clk = ~wr_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: plain item counts, no modulo pointers.
    int rd_cnt;
    int m_wcnt;
    int m_rs [SS];
    bit m_full, m_af, m_ovf;
    int m_lvl;
    logic [AS+DW-1:0] exp_q [$];

    function automatic logic [AS:0] gray5(input int c);
        logic [AS:0] b;
        b = 5'(c % 32);
        return b ^ (b >> 1);
    endfunction

    function automatic int nxt_used();
        return m_wcnt + ((wr_req && !m_full) ? 1 : 0) - m_rs[SS-1];
    endfunction

    always @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            m_wcnt <= 0;
            for (int i = 0; i < SS; i++) m_rs[i] <= 0;
            m_full <= 1'b0;
            m_af   <= 1'b0;
            m_ovf  <= 1'b0;
            m_lvl  <= 0;
        end else begin
            m_wcnt <= m_wcnt + ((wr_req && !m_full) ? 1 : 0);
            m_full <= (nxt_used() == DEPTH);
            m_af   <= ((DEPTH - nxt_used()) <= AF);
            m_lvl  <= nxt_used();
            m_ovf  <= (wr_req && m_full) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            m_rs[0] <= rd_cnt;
            for (int i = 1; i < SS; i++) m_rs[i] <= m_rs[i-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected write on every RAM strobe and checks flags each cycle.
    logic [AS:0] prev_g = '0;
    always @(negedge wr_clk) begin
        if (wr_rstn !== 1'b1) begin
            prev_g = '0;
        end else begin
            if (ram_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {28'd0, ram_wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    logic [AS+DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("ram_wr_addr", {28'd0, ram_wr_addr}, {28'd0, e[AS+DW-1:DW]});
                    chk("ram_wr_data", {16'd0, ram_wr_data}, {16'd0, e[DW-1:0]});
                end
            end
            chk("wr_ptr_gray", {27'd0, wr_ptr_gray}, {27'd0, gray5(m_wcnt)});
            chk("full", {31'd0, full}, {31'd0, m_full});
            chk("almost_full", {31'd0, almost_full}, {31'd0, m_af});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("gray_one_bit", ($countones(prev_g ^ wr_ptr_gray) <= 1) ? 32'd1 : 32'd0, 32'd1);
`ifdef FIFO_WR_LEVEL_EN
            chk("wr_level", {27'd0, wr_level}, m_lvl);
`endif
            prev_g = wr_ptr_gray;
        end
    end

    // Drive one cycle of stimulus just after a rising edge, then advance to the next one.
    task automatic step(input logic req, input logic clr);
        wr_req      = req;
        ovf_clr     = clr;
        wr_din      = 16'($urandom);
        rd_ptr_gray = gray5(rd_cnt);
        if (req && !m_full) exp_q.push_back({4'(m_wcnt % DEPTH), wr_din});
        @(posedge wr_clk);
        #1;
    endtask

    task automatic apply_reset();
        wr_rstn     = 1'b0;
        wr_req      = 1'b0;
        ovf_clr     = 1'b0;
        rd_cnt      = 0;
        rd_ptr_gray = '0;
        exp_q.delete();
        #1;
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_af", {31'd0, almost_full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_gray", {27'd0, wr_ptr_gray}, 32'd0);
        chk("rst_addr", {28'd0, ram_wr_addr}, 32'd0);
        chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
`ifdef FIFO_WR_LEVEL_EN
        chk("rst_level", {27'd0, wr_level}, 32'd0);
`endif
        repeat (2) @(posedge wr_clk);
        #3 wr_rstn = 1'b1;
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        wr_rstn = 1'b1; wr_req = 1'b0; ovf_clr = 1'b0; wr_din = '0; rd_ptr_gray = '0; rd_cnt = 0;
        #2;
        apply_reset();

        // Fill 16 entries with the reader idle.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0);
            if (i == 13) chk("af_after_13", {31'd0, almost_full}, 32'd0);
            if (i == 14) chk("af_after_14", {31'd0, almost_full}, 32'd1);
            if (i == 15) chk("full_after_15", {31'd0, full}, 32'd0);
        end
        chk("full_after_16", {31'd0, full}, 32'd1);
        chk("gray_after_16", {27'd0, wr_ptr_gray}, 32'b11000);

        // Rejected pushes, clear, and clear colliding with a rejected push.
        repeat (3) step(1'b1, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("gray_held", {27'd0, wr_ptr_gray}, 32'b11000);
        step(1'b0, 1'b1);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        step(1'b1, 1'b1);
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);

        // One read: full drops on the third edge after the read pointer moves.
        rd_cnt = 1;
        step(1'b0, 1'b0); chk("full_lag1", {31'd0, full}, 32'd1);
        step(1'b0, 1'b0); chk("full_lag2", {31'd0, full}, 32'd1);
        step(1'b0, 1'b0); chk("full_lag3", {31'd0, full}, 32'd0);
        step(1'b1, 1'b1);
        chk("full_refill", {31'd0, full}, 32'd1);

        // Streaming with the reader four entries behind.
        apply_reset();
        for (int i = 1; i <= 40; i++) begin
            rd_cnt = (m_wcnt >= 4) ? m_wcnt - 4 : 0;
            step(1'b1, 1'b0);
            chk("stream_msb", {31'd0, wr_ptr_gray[AS]}, (i / 16) % 2);
            chk("stream_not_full", {31'd0, full}, 32'd0);
        end

        // Reset in the middle of a burst.
        apply_reset();
        repeat (7) step(1'b1, 1'b0);
        chk("burst_addr7", {28'd0, ram_wr_addr}, 32'd7);
        wr_req = 1'b1;
        #1;
        apply_reset();
        step(1'b1, 1'b0);
        chk("post_rst_gray", {27'd0, wr_ptr_gray}, 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if (rd_cnt < m_wcnt && $urandom_range(0, 2) == 0) rd_cnt++;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end

`ifdef FIFO_WR_LEVEL_EN
        apply_reset();
        repeat (10) step(1'b1, 1'b0);
        chk("level_10", {27'd0, wr_level}, 32'd10);
        rd_cnt = 6;
        step(1'b0, 1'b0); chk("level_lag1", {27'd0, wr_level}, 32'd10);
        step(1'b0, 1'b0); chk("level_lag2", {27'd0, wr_level}, 32'd10);
        step(1'b0, 1'b0); chk("level_4", {27'd0, wr_level}, 32'd4);
        chk("level_af", {31'd0, almost_full}, 32'd0);
`endif

        step(1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
